// File: rtl/enigma_rotor_sequencer_if.sv
// Valid/ready character stream between the char source, the rotor sequencer and the display sink.
interface enigma_rotor_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;

    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_char
    );

    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_char
    );
endinterface

// File: rtl/enigma_rotor_sequencer.sv
// Three-rotor offset cipher with fixed reflector, one stage per clock.
// Rotors step (with middle-rotor double step) on accept of a letter.
module enigma_rotor_sequencer #(
    parameter logic [4:0] NOTCH_R0 = 5'd16,
    parameter logic [4:0] NOTCH_R1 = 5'd4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load_pos,
    input  logic [4:0]               pos_init_r0,
    input  logic [4:0]               pos_init_r1,
    input  logic [4:0]               pos_init_r2,
    enigma_rotor_sequencer_if.slave  bus,
    output logic [4:0]               pos_r0,
    output logic [4:0]               pos_r1,
    output logic [4:0]               pos_r2,
    output logic                     busy
);

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, REF, B2, B1, B0, OUT
    } state_t;

    state_t     state, next_state;
    logic [7:0] x;
    logic [7:0] stage_x;
    logic [7:0] out_char;
    logic       in_ready;
    logic       accept;
    logic       is_letter;

    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] norm_pos(input logic [4:0] p);
        return (p >= 5'd26) ? p - 5'd26 : p;
    endfunction

    function automatic logic [7:0] fwd(input logic [7:0] v, input logic [4:0] p);
        logic [7:0] s;
        s = v + {3'b000, p};
        return (s > 8'd90) ? s - 8'd26 : s;
    endfunction

    function automatic logic [7:0] bwd(input logic [7:0] v, input logic [4:0] p);
        logic [7:0] s;
        s = v - {3'b000, p};
        return (s < 8'd65) ? s + 8'd26 : s;
    endfunction

    assign in_ready      = (state == IDLE) && !load_pos;
    assign accept        = bus.in_valid && in_ready;
    assign is_letter     = (bus.in_char >= 8'd65) && (bus.in_char <= 8'd90);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == OUT);
    assign bus.out_char  = out_char;
    assign busy          = (state != IDLE);

    always_comb begin
        stage_x = x;
        case (state)
            F0:      stage_x = fwd(x, pos_r0);
            F1:      stage_x = fwd(x, pos_r1);
            F2:      stage_x = fwd(x, pos_r2);
            REF:     stage_x = 8'd155 - x;
            B2:      stage_x = bwd(x, pos_r2);
            B1:      stage_x = bwd(x, pos_r1);
            B0:      stage_x = bwd(x, pos_r0);
            default: stage_x = x;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = is_letter ? F0 : OUT;
            F0:      next_state = F1;
            F1:      next_state = F2;
            F2:      next_state = REF;
            REF:     next_state = B2;
            B2:      next_state = B1;
            B1:      next_state = B0;
            B0:      next_state = OUT;
            OUT:     if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x        <= '0;
            out_char <= '0;
            pos_r0   <= '0;
            pos_r1   <= '0;
            pos_r2   <= '0;
        end else begin
            if (state == IDLE && load_pos) begin
                pos_r0 <= norm_pos(pos_init_r0);
                pos_r1 <= norm_pos(pos_init_r1);
                pos_r2 <= norm_pos(pos_init_r2);
            end else if (accept) begin
                if (is_letter) begin
                    x      <= bus.in_char;
                    pos_r0 <= inc_pos(pos_r0);
                    // Middle rotor steps once whether carried by r0 or by its own notch (double step).
                    if (pos_r0 == NOTCH_R0 || pos_r1 == NOTCH_R1) pos_r1 <= inc_pos(pos_r1);
                    if (pos_r1 == NOTCH_R1) pos_r2 <= inc_pos(pos_r2);
                end else begin
                    out_char <= bus.in_char;
                end
            end
            if (state == B0)
                out_char <= stage_x;
            else if (state != IDLE && state != OUT)
                x <= stage_x;
        end
    end

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
// Directed bench for enigma_rotor_sequencer with hand-computed expected characters and positions.
module tb_enigma_rotor_sequencer;

    logic       clk;
    logic       resetn;
    logic       load_pos;
    logic [4:0] pos_init_r0, pos_init_r1, pos_init_r2;
    logic [4:0] pos_r0, pos_r1, pos_r2;
    logic       busy;
    int         total;
    int         bad;

    enigma_rotor_sequencer_if bus ();

    enigma_rotor_sequencer #(
        .NOTCH_R0(5'd16),
        .NOTCH_R1(5'd4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_pos   (load_pos),
        .pos_init_r0(pos_init_r0),
        .pos_init_r1(pos_init_r1),
        .pos_init_r2(pos_init_r2),
        .bus        (bus),
        .pos_r0     (pos_r0),
        .pos_r1     (pos_r1),
        .pos_r2     (pos_r2),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        load_pos    = 1'b1;
        pos_init_r0 = a;
        pos_init_r1 = b;
        pos_init_r2 = c;
        @(posedge clk); #1;
        load_pos = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, output logic [7:0] got, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        got = bus.out_char;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [7:0] got, got2;
    int         lat;
    logic [7:0] letters [4];
    logic [14:0] saved_pos;

    initial begin
        total         = 0;
        bad           = 0;
        resetn        = 1'b0;
        load_pos      = 1'b0;
        pos_init_r0   = '0;
        pos_init_r1   = '0;
        pos_init_r2   = '0;
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.out_ready = 1'b0;
        letters[0] = 8'h51; letters[1] = 8'h4D; letters[2] = 8'h5A; letters[3] = 8'h41;

        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        chk("reset_pos", {17'd0, pos_r2, pos_r1, pos_r0}, 32'd0);
        chk("reset_out_char", {24'd0, bus.out_char}, 32'd0);
        chk("reset_out_valid_busy", {30'd0, bus.out_valid, busy}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // A at 0/0/0 -> X, rotors 1/0/0
        send(8'h41, got, lat);
        chk("A_to_X", {24'd0, got}, 32'h58);
        chk("A_latency", lat, 32'd8);
        chk("A_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd0, 5'd0, 5'd1});
        chk("idle_after_out", {30'd0, bus.out_valid, busy}, 32'd0);

        load_pos = 1'b1;
        #1 chk("in_ready_low_on_load", {31'd0, bus.in_ready}, 32'd0);
        load_pos = 1'b0;
        load(5'd0, 5'd0, 5'd0);
        send(8'h58, got, lat);
        chk("X_to_A", {24'd0, got}, 32'h41);

        load(5'd23, 5'd7, 5'd2);
        send(8'h48, got, lat);
        chk("H_to_E", {24'd0, got}, 32'h45);
        chk("H_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd2, 5'd7, 5'd24});
        load(5'd23, 5'd7, 5'd2);
        send(8'h45, got, lat);
        chk("E_to_H", {24'd0, got}, 32'h48);

        for (int i = 0; i < 4; i++) begin
            load(5'd23, 5'd7, 5'd2);
            send(letters[i], got, lat);
            chk("never_self", {31'd0, (got == letters[i])}, 32'd0);
            load(5'd23, 5'd7, 5'd2);
            send(got, got2, lat);
            chk("roundtrip", {24'd0, got2}, {24'd0, letters[i]});
        end

        // 24/0/0, Z: r0 -> 25, F0 wraps 115 -> 89, result C
        load(5'd24, 5'd0, 5'd0);
        send(8'h5A, got, lat);
        chk("Z_to_C", {24'd0, got}, 32'h43);
        chk("Z_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd0, 5'd0, 5'd25});

        load(5'd16, 5'd4, 5'd0);
        send(8'h4B, got, lat);
        chk("double_step_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd1, 5'd5, 5'd17});
        load(5'd25, 5'd0, 5'd0);
        send(8'h4B, got, lat);
        chk("wrap_no_carry_pos", {17'd0, pos_r2, pos_r1, pos_r0}, 32'd0);
        load(5'd16, 5'd0, 5'd0);
        send(8'h4B, got, lat);
        chk("r0_carry_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd0, 5'd1, 5'd17});
        load(5'd3, 5'd4, 5'd0);
        send(8'h4B, got, lat);
        chk("r1_notch_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd1, 5'd5, 5'd4});

        load(5'd30, 5'd26, 5'd31);
        chk("load_fold_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, 5'd5, 5'd0, 5'd4});

        // Non-letter passes through in one cycle, held while the sink stalls
        saved_pos = {pos_r2, pos_r1, pos_r0};
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        chk("space_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("space_out_char", {24'd0, bus.out_char}, 32'h20);
        chk("space_pos", {17'd0, pos_r2, pos_r1, pos_r0}, {17'd0, saved_pos});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", {22'd0, bus.out_valid, bus.in_ready, bus.out_char}, {22'd0, 2'b10, 8'h20});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("stall_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

        // Reset while in REF aborts the letter
        load(5'd0, 5'd0, 5'd0);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h41;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("busy_in_ref", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_valid_busy", {30'd0, bus.out_valid, busy}, 32'd0);
        chk("abort_pos", {17'd0, pos_r2, pos_r1, pos_r0}, 32'd0);
        @(posedge clk);
        #2 resetn = 1'b1;
        send(8'h41, got, lat);
        chk("after_abort_A", {24'd0, got}, 32'h58);
        chk("after_abort_pos", {17'd0, pos_r2, pos_r1, pos_r0}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
